// File: rtl/bus_delay_pkg.sv
// Shared definitions for the bus delay controller.
//   state_t    : controller states (IDLE / WAIT / ISSUE / RESP)
//   DLY_W_DEF  : default width of the wait-state down-counter
//   STALL_MAX  : saturation value of the stall cycle counter
package bus_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int          DLY_W_DEF = 16;
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_delay_timer.sv
// Wait-state down-counter with clamp-on-load.
//   pclk, presetn : clock, asynchronous active-low reset
//   load          : load the clamped value of load_val
//   dec           : decrement by one (ignored while zero or loading)
//   load_val      : requested delay (32 bit, clamped to 2^DLY_W-1)
//   load_zero     : clamped load value is zero (combinational, for the FSM)
//   last          : counter currently reads 1 (final wait cycle)
module bus_delay_timer
  import bus_delay_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        load,
  input  logic        dec,
  input  logic [31:0] load_val,
  output logic        load_zero,
  output logic        last
);

  localparam logic [31:0] CLAMP_MAX = (32'd1 << DLY_W) - 32'd1;

  logic [DLY_W-1:0] load_d;
  logic [DLY_W-1:0] cnt_q;

  // Delays that do not fit the counter saturate instead of wrapping.
  assign load_d    = (load_val > CLAMP_MAX) ? CLAMP_MAX[DLY_W-1:0] : load_val[DLY_W-1:0];
  assign load_zero = (load_d == '0);
  assign last      = (cnt_q == DLY_W'(1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_d;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DLY_W'(1);
    end
  end

endmodule

// File: rtl/bus_delay_ctrl.sv
// Wait-state scheduler between a bus master and a memory-side slave.
// Each accepted request is held for cfg_delay cycles (clamped to
// 2^DLY_W-1), then issued to the slave; the slave response is returned
// to the master as a one-cycle pulse. Inserted wait cycles are counted
// in a saturating 32-bit counter.
//
// Handshakes: a request transfers on a cycle where vld and rdy are both
// high at the rising pclk edge. s_req_vld stays high with stable fields
// until s_req_rdy. s_rsp_vld and m_rsp_vld are unconditional one-cycle
// pulses (no back-pressure).
//
// Ports:
//   pclk, presetn                    : clock, asynchronous active-low reset
//   cfg_delay                        : delay in cycles, sampled at acceptance
//   m_req_vld/rdy/addr/wr/wdata      : master request channel
//   s_req_vld/rdy/addr/wr/wdata      : slave request channel (registered fields)
//   s_rsp_vld, s_rsp_rdata           : slave response pulse and read data
//   m_rsp_vld, m_rsp_rdata           : master response pulse and read data
//   busy                             : any state other than IDLE
//   stall_clr, stall_cnt             : clear / value of the wait-cycle counter
module bus_delay_ctrl
  import bus_delay_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int AW    = 32
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic [31:0]   cfg_delay,
  input  logic          m_req_vld,
  output logic          m_req_rdy,
  input  logic [AW-1:0] m_req_addr,
  input  logic          m_req_wr,
  input  logic [31:0]   m_req_wdata,
  output logic          s_req_vld,
  input  logic          s_req_rdy,
  output logic [AW-1:0] s_req_addr,
  output logic          s_req_wr,
  output logic [31:0]   s_req_wdata,
  input  logic          s_rsp_vld,
  input  logic [31:0]   s_rsp_rdata,
  output logic          m_rsp_vld,
  output logic [31:0]   m_rsp_rdata,
  output logic          busy,
  input  logic          stall_clr,
  output logic [31:0]   stall_cnt
);

  state_t        state_q;
  state_t        state_d;
  logic          accept;
  logic          rsp_take;
  logic          in_wait;
  logic          tmr_zero;
  logic          tmr_last;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic          rsp_vld_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   stall_cnt_q;

  bus_delay_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .pclk      (pclk),
    .presetn   (presetn),
    .load      (accept),
    .dec       (in_wait),
    .load_val  (cfg_delay),
    .load_zero (tmr_zero),
    .last      (tmr_last)
  );

  // The response pulse cycle is still spent in RESP, so the master cannot
  // be accepted again until the cycle after m_rsp_vld.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m_req_vld) begin
          accept  = 1'b1;
          state_d = tmr_zero ? ST_ISSUE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_last) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (s_req_rdy) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_vld_q) begin
          state_d = ST_IDLE;
        end else if (s_rsp_vld) begin
          rsp_take = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_wait   = (state_q == ST_WAIT);
  assign m_req_rdy = (state_q == ST_IDLE);
  assign s_req_vld = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= m_req_addr;
      wr_q    <= m_req_wr;
      wdata_q <= m_req_wdata;
    end
  end

  // Writes return zero data so the master never sees stale read data.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_vld_q <= rsp_take;
      if (rsp_take) begin
        rsp_rdata_q <= wr_q ? 32'd0 : s_rsp_rdata;
      end
    end
  end

  // Clear has priority over a concurrent wait-cycle increment.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      stall_cnt_q <= '0;
    end else if (stall_clr) begin
      stall_cnt_q <= '0;
    end else if (in_wait && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign s_req_addr  = addr_q;
  assign s_req_wr    = wr_q;
  assign s_req_wdata = wdata_q;
  assign m_rsp_vld   = rsp_vld_q;
  assign m_rsp_rdata = rsp_rdata_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_bus_delay_ctrl.sv
module tb_bus_delay_ctrl;

  localparam int AW = 32;

  logic          pclk;
  logic          presetn;
  logic [31:0]   cfg_delay;
  logic          m_req_vld;
  logic          m_req_rdy;
  logic [AW-1:0] m_req_addr;
  logic          m_req_wr;
  logic [31:0]   m_req_wdata;
  logic          s_req_vld;
  logic          s_req_rdy;
  logic [AW-1:0] s_req_addr;
  logic          s_req_wr;
  logic [31:0]   s_req_wdata;
  logic          s_rsp_vld;
  logic [31:0]   s_rsp_rdata;
  logic          m_rsp_vld;
  logic [31:0]   m_rsp_rdata;
  logic          busy;
  logic          stall_clr;
  logic [31:0]   stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_stall;

  bus_delay_ctrl #(.DLY_W(16), .AW(AW)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cfg_delay   (cfg_delay),
    .m_req_vld   (m_req_vld),
    .m_req_rdy   (m_req_rdy),
    .m_req_addr  (m_req_addr),
    .m_req_wr    (m_req_wr),
    .m_req_wdata (m_req_wdata),
    .s_req_vld   (s_req_vld),
    .s_req_rdy   (s_req_rdy),
    .s_req_addr  (s_req_addr),
    .s_req_wr    (s_req_wr),
    .s_req_wdata (s_req_wdata),
    .s_rsp_vld   (s_rsp_vld),
    .s_rsp_rdata (s_rsp_rdata),
    .m_rsp_vld   (m_rsp_vld),
    .m_rsp_rdata (m_rsp_rdata),
    .busy        (busy),
    .stall_clr   (stall_clr),
    .stall_cnt   (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge pclk) begin
    if (presetn && m_rsp_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got m_rsp_vld=1 rdata=%h want no response at %0t",
                 m_rsp_rdata, $time);
      end else begin
        chk("m_rsp_rdata", m_rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_req_vld"},   {31'd0, s_req_vld}, 32'd0);
    chk({tag, "_s_req_addr"},  s_req_addr, 32'd0);
    chk({tag, "_s_req_wr"},    {31'd0, s_req_wr}, 32'd0);
    chk({tag, "_s_req_wdata"}, s_req_wdata, 32'd0);
    chk({tag, "_m_rsp_vld"},   {31'd0, m_rsp_vld}, 32'd0);
    chk({tag, "_m_rsp_rdata"}, m_rsp_rdata, 32'd0);
    chk({tag, "_busy"},        {31'd0, busy}, 32'd0);
    chk({tag, "_stall_cnt"},   stall_cnt, 32'd0);
  endtask

  // ---------------- driver ----------------
  // mode: 0 plain, 1 change cfg_delay to 10 during WAIT,
  //       2 spurious s_rsp_vld during WAIT, 3 stall_cnt saturation/clear
  task automatic do_req(input logic [31:0] cfg, input int exp_d,
                        input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int hold, input int mode);
    int  k;
    bit  found;
    @(negedge pclk);
    chk("m_req_rdy_idle", {31'd0, m_req_rdy}, 32'd1);
    cfg_delay   = cfg;
    m_req_vld   = 1'b1;
    m_req_addr  = addr;
    m_req_wr    = wr;
    m_req_wdata = wdata;
    k     = 0;
    found = 1'b0;
    while (!found && k < exp_d + 10) begin
      @(negedge pclk);
      k++;
      m_req_vld = 1'b0;
      s_rsp_vld = 1'b0;
      stall_clr = 1'b0;
      if (mode == 1 && k == 1) cfg_delay = 32'd10;
      if (mode == 2 && k == 2) begin
        s_rsp_vld   = 1'b1;
        s_rsp_rdata = 32'h1234_5678;
      end
      if (mode == 3) begin
        if (k == 2) begin
          force dut.stall_cnt_q = 32'hFFFF_FFFE;
          #1;
          release dut.stall_cnt_q;
        end
        if (k == 3) chk("stall_sat_edge", stall_cnt, 32'hFFFF_FFFF);
        if (k == 4) begin
          chk("stall_sat_hold", stall_cnt, 32'hFFFF_FFFF);
          stall_clr = 1'b1;
        end
        if (k == 5) chk("stall_clr_wins", stall_cnt, 32'd0);
      end
      if (k < exp_d + 1) chk("m_req_rdy_wait", {31'd0, m_req_rdy}, 32'd0);
      if (s_req_vld) found = 1'b1;
    end
    s_rsp_vld = 1'b0;
    stall_clr = 1'b0;
    if (!found) begin
      chk("s_req_vld_timeout", 32'd0, 32'd1);
      return;
    end
    chk("issue_latency", k, exp_d + 1);
    chk("s_req_addr",  s_req_addr, addr);
    chk("s_req_wr",    {31'd0, s_req_wr}, {31'd0, wr});
    chk("s_req_wdata", s_req_wdata, wdata);
    for (int h = 0; h < hold; h++) begin
      s_req_rdy = 1'b0;
      @(negedge pclk);
      chk("hold_s_req_vld", {31'd0, s_req_vld}, 32'd1);
      chk("hold_s_req_addr", s_req_addr, addr);
      chk("hold_s_req_wdata", s_req_wdata, wdata);
    end
    s_req_rdy = 1'b1;
    @(negedge pclk);
    s_req_rdy = 1'b0;
    chk("resp_s_req_vld", {31'd0, s_req_vld}, 32'd0);
    chk("resp_busy", {31'd0, busy}, 32'd1);
    @(negedge pclk);
    // cycle R: slave response
    s_rsp_vld   = 1'b1;
    s_rsp_rdata = rdata;
    exp_q.push_back(wr ? 32'd0 : rdata);
    @(negedge pclk);
    // cycle R+1: response pulse, master still blocked
    s_rsp_vld   = 1'b0;
    s_rsp_rdata = 32'hFFFF_0000;
    chk("m_req_rdy_r1", {31'd0, m_req_rdy}, 32'd0);
    @(negedge pclk);
    // cycle R+2: back in IDLE
    chk("m_req_rdy_r2", {31'd0, m_req_rdy}, 32'd1);
    chk("busy_r2", {31'd0, busy}, 32'd0);
    chk("rsp_consumed", exp_q.size(), 32'd0);
    exp_q.delete();
    if (mode == 3) exp_stall = 32'd2 + 32'(exp_d - 6);
    else exp_stall = exp_stall + 32'(exp_d);
    chk("stall_cnt", stall_cnt, exp_stall);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rsp_seen;
    presetn     = 1'b0;
    cfg_delay   = 32'd0;
    m_req_vld   = 1'b0;
    m_req_addr  = '0;
    m_req_wr    = 1'b0;
    m_req_wdata = '0;
    s_req_rdy   = 1'b0;
    s_rsp_vld   = 1'b0;
    s_rsp_rdata = '0;
    stall_clr   = 1'b0;
    exp_stall   = 32'd0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check_reset_vals("rst");
    chk("rst_m_req_rdy", {31'd0, m_req_rdy}, 32'd1);

    // zero delay read
    do_req(32'd0, 0, 32'h100, 1'b0, 32'd0, 32'hA5A5_0001, 0, 0);
    // delay 5 write
    do_req(32'd5, 5, 32'h40, 1'b1, 32'hDEAD_BEEF, 32'h7777_7777, 0, 0);
    // cfg change mid-WAIT affects only the next request
    do_req(32'd3, 3, 32'h200, 1'b0, 32'd0, 32'h0BAD_F00D, 0, 1);
    chk("cfg_after_change", cfg_delay, 32'd10);
    // next request waits 10; slave stalls 4 cycles; spurious response in WAIT
    do_req(32'd10, 10, 32'h300, 1'b1, 32'hCAFE_0001, 32'h5555_AAAA, 4, 2);
    // clamped delay
    do_req(32'h0001_0003, 65535, 32'h400, 1'b0, 32'd0, 32'h0000_FFFF, 0, 0);

    // reset during WAIT drops the request
    @(negedge pclk);
    cfg_delay   = 32'd8;
    m_req_vld   = 1'b1;
    m_req_addr  = 32'h55;
    m_req_wr    = 1'b1;
    m_req_wdata = 32'h1111_2222;
    @(negedge pclk);
    m_req_vld = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    #1;
    check_reset_vals("wait_rst");
    @(negedge pclk);
    presetn = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge pclk);
      if (m_rsp_vld || s_req_vld) rsp_seen++;
    end
    chk("no_rsp_after_rst", rsp_seen, 32'd0);
    chk("post_rst_m_req_rdy", {31'd0, m_req_rdy}, 32'd1);
    exp_stall = 32'd0;

    // saturation and clear-with-increment
    do_req(32'd6, 6, 32'h600, 1'b0, 32'd0, 32'h6666_0006, 0, 3);

    repeat (3) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_delay_ctrl.md
# bus_delay_ctrl

Wait-state scheduler that enforces the programmed bus delay on a single-outstanding request channel between a bus master and a memory-side slave. It takes the delay value from the APB delay register (`cfg_delay`), holds each accepted request for that many `pclk` cycles, then issues it to the slave and returns the slave's response to the master. It also keeps a saturating count of inserted wait cycles for software profiling.

## Interface
- `DLY_W`, 16: width of the internal delay down-counter; larger `cfg_delay` values clamp to 2^DLY_W-1.
- `AW`, 32: request address width.

- `pclk`, in, 1: clock.
- `presetn`, in, 1: asynchronous active-low reset.
- `cfg_delay`, in, 32: programmed delay in cycles, from the APB delay register.
- `m_req_vld`, in, 1: master request valid.
- `m_req_rdy`, out, 1: request accepted when high together with `m_req_vld`.
- `m_req_addr`, in, AW: request address.
- `m_req_wr`, in, 1: request is a write when high.
- `m_req_wdata`, in, 32: write data.
- `s_req_vld`, out, 1: request valid toward the slave.
- `s_req_rdy`, in, 1: slave accepts the request.
- `s_req_addr`, out, AW: registered copy of the accepted address.
- `s_req_wr`, out, 1: registered copy of the accepted direction.
- `s_req_wdata`, out, 32: registered copy of the accepted write data.
- `s_rsp_vld`, in, 1: slave response pulse; the slave cannot be back-pressured.
- `s_rsp_rdata`, in, 32: slave read data.
- `m_rsp_vld`, out, 1: one-cycle response pulse to the master.
- `m_rsp_rdata`, out, 32: read data, valid with `m_rsp_vld`.
- `busy`, out, 1: high in every state except IDLE.
- `stall_clr`, in, 1: synchronous clear of `stall_cnt`.
- `stall_cnt`, out, 32: total inserted wait cycles, saturating.

## Operation
- FSM states: IDLE, WAIT, ISSUE, RESP.
- IDLE: `m_req_rdy`=1. On `m_req_vld`, capture addr/wr/wdata and load the counter with D = min(`cfg_delay`, 2^DLY_W-1). Go to WAIT if D>0, otherwise to ISSUE.
- WAIT: decrement the counter each cycle and increment `stall_cnt`. Go to ISSUE in the cycle the counter reads 1, so WAIT lasts exactly D cycles.
- ISSUE: `s_req_vld`=1 with the captured fields held stable. On `s_req_rdy`, go to RESP.
- RESP: wait for `s_rsp_vld`. Register `s_rsp_rdata`, pulse `m_rsp_vld` in the following cycle, then return to IDLE. Writes also produce an `m_rsp_vld` pulse, with `m_rsp_rdata`=0.
- `cfg_delay` is sampled only at acceptance. Changes while the block is busy affect only the next request.
- `s_rsp_vld` outside RESP is ignored.
- `stall_cnt` saturates at 0xFFFFFFFF. If `stall_clr` and an increment occur in the same cycle, the clear wins and the result is 0.
- `m_req_rdy` is low in WAIT, ISSUE and RESP. Only one request is outstanding at a time.

## Timing
- Reset (asynchronous, any state): state=IDLE, counter=0.
- Reset values of outputs: `m_req_rdy`=1 once `presetn` is high; `s_req_vld`=0; `s_req_addr`/`s_req_wr`/`s_req_wdata`=0; `m_rsp_vld`=0; `m_rsp_rdata`=0; `busy`=0; `stall_cnt`=0.
- A request in flight when reset asserts is dropped and produces no response.
- Handshake at edge 0 puts `s_req_vld` high from cycle D+1. D=0 gives one cycle of latency.
- `s_rsp_vld` in cycle R puts `m_rsp_vld` high in cycle R+1. The earliest next acceptance is cycle R+2.
- `s_req_vld` never deasserts before `s_req_rdy`.

## Structure
- `bus_delay_pkg` holds:
  - the state enum (IDLE/WAIT/ISSUE/RESP);
  - the `DLY_W` default;
  - the `STALL_MAX` constant (32'hFFFF_FFFF).
- Sub-module `bus_delay_timer`: load/decrement counter with clamp logic and a `last` flag. The FSM and capture registers stay in `bus_delay_ctrl`.

## Test plan
- `cfg_delay`=0, read request at 0x100, slave ready immediately, `rdata`=0xA5A5_0001 → `s_req_vld` in cycle 1, `m_rsp_rdata`=0xA5A5_0001, `stall_cnt`=0.
- `cfg_delay`=5, write 0xDEAD_BEEF to 0x40 → `s_req_vld` first high in cycle 6, `stall_cnt`=5, write response `m_rsp_rdata`=0.
- `cfg_delay`=0x0001_0003 with DLY_W=16 → WAIT lasts 65535 cycles, `stall_cnt`=65535.
- `cfg_delay` changed from 3 to 10 during WAIT → current request still waits 3; the next request waits 10.
- Hold `s_req_rdy`=0 for 4 cycles in ISSUE and inject a spurious `s_rsp_vld` during WAIT → fields stay stable; the spurious pulse is ignored with no `m_rsp_vld`.
- Assert `presetn` low during WAIT, preload `stall_cnt`=0xFFFF_FFFE, pulse `stall_clr` during an increment:
  - reset: all outputs return to reset values and no response is produced;
  - preload: saturates at 0xFFFF_FFFF;
  - clear with increment: yields 0.
